multiport_reg_file: RTL

Parametrised general-purpose register file for the RISC-V core, generalising the existing single-write, dual-read register file.
- NUM_RD asynchronous read ports and NUM_WR synchronous write ports with fixed priority.
- Optional hardwired-zero register 0.
- Per-register busy scoreboard, set at issue and cleared at writeback, so the decode/issue stage can detect RAW hazards.

---
 rtl/multiport_reg_file.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/multiport_reg_file.sv
// -----------------------------------------------------------------------------
// multiport_reg_file
//
// General-purpose register file for the RISC-V core with NUM_RD combinational
// read ports, NUM_WR clocked write ports and a per-register busy scoreboard
// that the issue stage uses to detect RAW hazards.
//
// Parameters:
//    XLEN     - data width of each register
//    DEPTH    - number of registers
//    AW       - address width, derived from DEPTH (not meant to be overridden)
//    NUM_RD   - number of read ports
//    NUM_WR   - number of write ports (highest index wins on address clashes)
//    ZERO_REG - nonzero: register 0 reads 0, ignores writes, never busy
//
// Ports:
//    clk       in   clock
//    reset     in   asynchronous, active-high; clears registers and scoreboard
//    rd_addr   in   NUM_RD*AW    read addresses, port k at [k*AW +: AW]
//    rd_data   out  NUM_RD*XLEN  read data, port k at [k*XLEN +: XLEN]
//    rd_busy   out  NUM_RD       busy bit of the register each read port sees
//    wr_en     in   NUM_WR       write enables
//    wr_addr   in   NUM_WR*AW    write addresses
//    wr_data   in   NUM_WR*XLEN  write data
//    iss_en    in   mark iss_addr busy at the next edge
//    iss_addr  in   AW           destination register being issued
//    busy_vec  out  DEPTH        scoreboard view, bit i = register i busy
//
// Optional feature, macro REGFILE_BYPASS_EN:
//    When defined, a write in flight this cycle is forwarded to any read port
//    addressing the same register, and the scoreboard view reports the
//    writeback as already retired (unless an issue to that register is also
//    happening this cycle). When undefined, reads and busy bits reflect only
//    the registered state.
// -----------------------------------------------------------------------------
module multiport_reg_file #(
   parameter int XLEN     = 64,
   parameter int DEPTH    = 32,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int ZERO_REG = 1,
   localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*AW-1:0]     rd_addr,
   output logic [NUM_RD*XLEN-1:0]   rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*AW-1:0]     wr_addr,
   input  logic [NUM_WR*XLEN-1:0]   wr_data,
   input  logic                     iss_en,
   input  logic [AW-1:0]            iss_addr,
   output logic [DEPTH-1:0]         busy_vec
);

   logic [XLEN-1:0] regs      [DEPTH];
   logic [DEPTH-1:0] busy;

   logic [DEPTH-1:0] wr_hit;
   logic [XLEN-1:0]  wr_val    [DEPTH];
   logic [DEPTH-1:0] iss_hit;
   logic [DEPTH-1:0] busy_nxt;

   logic [XLEN-1:0]  data_view [DEPTH];
   logic [DEPTH-1:0] busy_view;

   // Register 0 is excluded from every write and issue when it is hardwired.
   function automatic logic writable(input int idx);
      return !((ZERO_REG != 0) && (idx == 0));
   endfunction

   // Per-register write decode. Scanning ports in ascending order means the
   // highest-indexed enabled port addressing a register is the one that
   // sticks. Addresses at or beyond DEPTH match no register, so such writes
   // and issues simply fall away. The scoreboard's next state follows: an
   // issue sets, a writeback clears, and set beats clear because the issuing
   // instruction is the newer producer.
   always_comb begin
      wr_hit  = '0;
      iss_hit = '0;
      for (int i = 0; i < DEPTH; i++) begin
         wr_val[i] = '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
         for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(i)) && writable(i)) begin
               wr_hit[i] = 1'b1;
               wr_val[i] = wr_data[j*XLEN +: XLEN];
            end
         end
         iss_hit[i] = iss_en && (iss_addr == AW'(i)) && writable(i);
      end
      busy_nxt = iss_hit | (busy & ~wr_hit);
   end

   // Register storage: plain flops, cleared by the async reset, updated only
   // where the write decode found a winning port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_hit[i]) begin
               regs[i] <= wr_val[i];
            end
         end
      end
   end

   // Busy scoreboard. Bit 0 can never be set when register 0 is hardwired
   // because iss_hit[0] is forced low by the decode above.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   // What the outside world sees for each register. With forwarding enabled
   // an in-flight write replaces the stored value and retires the busy bit,
   // except that a same-cycle issue keeps it busy. Forwarding is held off
   // during reset so every output reads as zero while reset is asserted.
   always_comb begin
      busy_view = '0;
      for (int i = 0; i < DEPTH; i++) begin
`ifdef REGFILE_BYPASS_EN
         if (wr_hit[i] && !reset) begin
            data_view[i] = wr_val[i];
            busy_view[i] = iss_hit[i];
         end else begin
            data_view[i] = regs[i];
            busy_view[i] = busy[i];
         end
`else
         data_view[i] = regs[i];
         busy_view[i] = busy[i];
`endif
      end
   end

   assign busy_vec = busy_view;

   // Read ports are independent muxes over the register view. An address
   // that matches no register leaves the zero defaults in place.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr[k*AW +: AW] == AW'(i)) begin
               rd_data[k*XLEN +: XLEN] = data_view[i];
               rd_busy[k]              = busy_view[i];
            end
         end
      end
   end

endmodule
